// File: rtl/pingpong_drain.sv
// Read-side drain engine for a ping-pong buffer half: walks the pop address,
// captures synchronous read data into a 2-entry skid FIFO and streams it out.
module pingpong_drain #(
    parameter int bitwidth    = 32,
    parameter int nrOfEntries = 128
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic [$clog2(nrOfEntries):0]    count,
    output logic [$clog2(nrOfEntries)-1:0]  popAddress,
    input  logic [bitwidth-1:0]             popData,
    output logic [bitwidth-1:0]             outData,
    output logic                            outValid,
    input  logic                            outReady,
    output logic                            busy,
    output logic                            done
);
    localparam int AW = $clog2(nrOfEntries);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state;
    state_t              stateNext;
    logic [CW-1:0]       drainCount;
    logic [CW-1:0]       issued;
    logic [CW-1:0]       accepted;
    logic [CW-1:0]       addrLast;
    logic                rdPending;
    logic [1:0]          occ;
    logic [2:0]          occProj;
    logic                wrPtr;
    logic                rdPtr;
    logic [bitwidth-1:0] fifo [2];
    logic                xfer;
    logic                issue;
    logic                lastXfer;

    function automatic logic [CW-1:0] clampCount(input logic [CW-1:0] c);
        if (c > CW'(nrOfEntries)) begin
            return CW'(nrOfEntries);
        end
        return c;
    endfunction

    assign outValid = (occ != 2'd0);
    assign outData  = outValid ? fifo[rdPtr] : '0;
    assign xfer     = outValid && outReady;
    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign addrLast = drainCount - CW'(1);
    assign lastXfer = xfer && (accepted == addrLast);

    // Occupancy once the read already in flight lands and this edge's transfer leaves.
    assign occProj = {1'b0, occ} + {2'b00, rdPending} - {2'b00, xfer};
    assign issue   = (state == RUN) && (issued < drainCount) && (occProj < 3'd2);

    // Once every read is issued the address parks on the last word instead of running past it.
    always_comb begin
        popAddress = '0;
        if (state == RUN) begin
            if (issued < drainCount) begin
                popAddress = issued[AW-1:0];
            end else begin
                popAddress = addrLast[AW-1:0];
            end
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = (count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (lastXfer) begin
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            drainCount <= '0;
            issued     <= '0;
            accepted   <= '0;
            rdPending  <= 1'b0;
            occ        <= 2'd0;
            wrPtr      <= 1'b0;
            rdPtr      <= 1'b0;
        end else begin
            state <= stateNext;
            if (state == IDLE && start) begin
                drainCount <= clampCount(count);
                issued     <= '0;
                accepted   <= '0;
            end else begin
                if (issue) begin
                    issued <= issued + CW'(1);
                end
                if (xfer) begin
                    accepted <= accepted + CW'(1);
                end
            end
            // Read stage: popData for the address issued last cycle arrives now.
            rdPending <= issue;
            if (rdPending) begin
                wrPtr <= ~wrPtr;
            end
            if (xfer) begin
                rdPtr <= ~rdPtr;
            end
            occ <= occ + {1'b0, rdPending} - {1'b0, xfer};
        end
    end

    // Capture stage: data storage carries no reset, the pointers and occupancy guard it.
    always_ff @(posedge clock) begin
        if (rdPending) begin
            fifo[wrPtr] <= popData;
        end
    end

endmodule
